wide_add_seq: RTL

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_pkg.sv | 7 +
 rtl/wide_add_seq_add64_word.sv | 31 +++
 rtl/wide_add_seq.sv | 83 ++++++++
 3 files changed

// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared word width, FSM states and op encodings for wide_add_seq
package wide_add_pkg;
  localparam int WORD_W = 64;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/wide_add_seq_add64_word.sv
// add64_word: combinational 64-bit carry-lookahead slice built from 4-bit lookahead groups
module add64_word
  import wide_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              c63
);
  logic [WORD_W-1:0] w_g, w_p;
  logic [WORD_W:0]   w_c;
  assign w_g = a & b;
  assign w_p = a ^ b;
  // Each group's carry-out is formed from group generate/propagate and the group carry-in.
  always_comb begin
    w_c = '0;
    w_c[0] = cin;
    for (int k = 0; k < WORD_W; k += 4) begin
      w_c[k+1] = w_g[k] | (w_p[k] & w_c[k]);
      w_c[k+2] = w_g[k+1] | (w_p[k+1] & w_g[k]) | (&w_p[k+:2] & w_c[k]);
      w_c[k+3] = w_g[k+2] | (w_p[k+2] & w_g[k+1]) | (&w_p[k+1+:2] & w_g[k]) | (&w_p[k+:3] & w_c[k]);
      w_c[k+4] = w_g[k+3] | (w_p[k+3] & w_g[k+2]) | (&w_p[k+2+:2] & w_g[k+1])
               | (&w_p[k+1+:3] & w_g[k]) | (&w_p[k+:4] & w_c[k]);
    end
  end
  assign sum  = w_p ^ w_c[WORD_W-1:0];
  assign cout = w_c[WORD_W];
  assign c63  = w_c[WORD_W-1];
endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: word-serial NWORDS*64-bit add/sub through one 64-bit slice; WIDE_ADD_SEQ_OVF_EN enables out_ovf
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int NWORDS = 4
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sub,
  input  logic [NWORDS*WORD_W-1:0] in_a,
  input  logic [NWORDS*WORD_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NWORDS*WORD_W-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_ovf
);
  localparam int W  = NWORDS * WORD_W;
  localparam int IW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  state_t            r_state;
  logic [W-1:0]      r_a, r_b, r_sum;
  logic [IW-1:0]     r_idx;
  logic              r_carry, r_cout;
  logic [WORD_W-1:0] w_sum;
  logic              w_cout, w_c63, w_last;
  assign w_last = r_idx == IW'(NWORDS - 1);
  add64_word u_add (
    .a    (r_a[WORD_W*r_idx +: WORD_W]),
    .b    (r_b[WORD_W*r_idx +: WORD_W]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout),
    .c63  (w_c63)
  );
  // Subtraction is A + ~B + 1: B is inverted at capture and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_a     <= in_a;
        r_b     <= in_sub == OP_SUB ? ~in_b : in_b;
        r_carry <= in_sub;
        r_idx   <= '0;
        r_state <= RUN;
      end
    end else if (r_state == RUN) begin
      r_sum[WORD_W*r_idx +: WORD_W] <= w_sum;
      r_carry <= w_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout  <= w_cout;
        r_state <= DONE;
      end
    end else if (out_ready) begin
      r_state <= IDLE;
    end
  end
`ifdef WIDE_ADD_SEQ_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if (r_state == RUN && w_last) r_ovf <= w_c63 ^ w_cout;
  end
  assign out_ovf = r_ovf;
`else
  logic w_unused_c63;
  assign w_unused_c63 = w_c63;
  assign out_ovf = 1'b0;
`endif
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
endmodule
